// File: rtl/atconv_layer_mem_if.sv
// Conv-engine / dump-sink port bundle for the ATCONV layer memory.
// master = engine and sink side, slave = memory side.
interface atconv_layer_mem_if #(
    parameter int DW = 13,
    parameter int AW = 12
);
    logic          busy;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          csel;
    logic          dump_start;
    logic          dump_sel;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_done;
    logic          err_oor;
    logic          err_clash;

    modport master (
        output busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
               dump_start, dump_sel, dump_ready,
        input  cdata_rd, dump_valid, dump_addr, dump_data, dump_done,
               err_oor, err_clash
    );

    modport slave (
        input  busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
               dump_start, dump_sel, dump_ready,
        output cdata_rd, dump_valid, dump_addr, dump_data, dump_done,
               err_oor, err_clash
    );
endinterface

// File: rtl/atconv_layer_mem.sv
// Layer-0 / layer-1 banks for the ATCONV engine with a valid/ready bank dump streamer.
//   state  | meaning
//   IDLE   | waiting for dump_start while busy is low
//   FILL   | reading word 0 of the selected bank
//   STREAM | presenting words, advancing on each handshake
//   DONE   | dump_done pulse, back to IDLE
module atconv_layer_mem #(
    parameter int DW       = 13,
    parameter int AW       = 12,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    atconv_layer_mem_if.slave    bus
);
    localparam int L0_AW = $clog2(L0_DEPTH);
    localparam int L1_AW = $clog2(L1_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    logic [DW-1:0] l0_mem [L0_DEPTH];
    logic [DW-1:0] l1_mem [L1_DEPTH];

    state_t        state;
    logic          dsel;
    logic [DW-1:0] cdata_rd;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_done;
    logic          err_oor;
    logic          err_clash;

    logic          wr_oor;
    logic          rd_oor;
    logic          wr_ok;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] last_addr;

    assign wr_oor    = bus.csel && (bus.caddr_wr >= AW'(L1_DEPTH));
    assign rd_oor    = bus.csel && (bus.caddr_rd >= AW'(L1_DEPTH));
    assign wr_ok     = bus.cwr && !wr_oor;
    assign next_addr = dump_addr + AW'(1);
    assign last_addr = dsel ? AW'(L1_DEPTH - 1) : AW'(L0_DEPTH - 1);

    // Bank storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.csel)
                l1_mem[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
            else
                l0_mem[bus.caddr_wr[L0_AW-1:0]] <= bus.cdata_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdata_rd <= '0;
        end else if (bus.crd) begin
            if (rd_oor)
                cdata_rd <= '0;
            else if (wr_ok && (bus.caddr_wr == bus.caddr_rd))
                cdata_rd <= bus.cdata_wr;
            else if (bus.csel)
                cdata_rd <= l1_mem[bus.caddr_rd[L1_AW-1:0]];
            else
                cdata_rd <= l0_mem[bus.caddr_rd[L0_AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_oor   <= 1'b0;
            err_clash <= 1'b0;
        end else begin
            if ((bus.cwr && wr_oor) || (bus.crd && rd_oor))
                err_oor <= 1'b1;
            if (bus.cwr && (state != IDLE))
                err_clash <= 1'b1;
        end
    end

    // On a handshake the read address is steered to the following word, so the
    // synchronous read lands in dump_data in time for the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dsel       <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dump_start && !bus.busy) begin
                        dsel      <= bus.dump_sel;
                        dump_addr <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    dump_data  <= dsel ? l1_mem[0] : l0_mem[0];
                    dump_addr  <= '0;
                    dump_valid <= 1'b1;
                    state      <= STREAM;
                end
                STREAM: begin
                    if (bus.dump_ready) begin
                        if (dump_addr == last_addr) begin
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dump_addr <= next_addr;
                            dump_data <= dsel ? l1_mem[next_addr[L1_AW-1:0]]
                                              : l0_mem[next_addr[L0_AW-1:0]];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cdata_rd   = cdata_rd;
    assign bus.dump_valid = dump_valid;
    assign bus.dump_addr  = dump_addr;
    assign bus.dump_data  = dump_data;
    assign bus.dump_done  = dump_done;
    assign bus.err_oor    = err_oor;
    assign bus.err_clash  = err_clash;
endmodule
